hp_align_stage: RTL

Pipelined operand-alignment stage that sits directly upstream of the half-precision adder. It accepts two IEEE-754 binary16 operands and an add/sub op over a valid/ready handshake, then classifies both operands and applies the subtract negation. It also selects the larger-exponent operand and right-shifts the other mantissa by the exponent difference. It delivers the aligned mantissas, big exponent, signs and control class to the adder core two cycles later, sustaining one operation per cycle.

---
 rtl/hp_align_stage_pkg.sv | 20 ++
 rtl/hp_align_stage_if.sv | 31 +++
 rtl/hp_align_stage_shift.sv | 22 ++
 rtl/hp_align_stage.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hp_align_stage_pkg.sv
// Shared binary16 field widths and add-path class encodings used by the alignment stage.
package fp_pkg;

    localparam int HP_EXP_W   = 5;
    localparam int HP_FRAC_W  = 10;
    localparam int HP_EXP_MAX = 31;
    localparam int MANT_W     = 13;

    typedef enum logic [1:0] {
        CF_SPECIAL = 2'b00,
        CF_SUBN    = 2'b01,
        CF_NORM    = 2'b11
    } cf_e;

    // {hidden, frac, guard pair}; hidden is set for any non-zero exponent field
    function automatic logic [MANT_W-1:0] hp_mant(input logic [15:0] x);
        return {|x[14:10], x[9:0], 2'b00};
    endfunction

endpackage

// File: rtl/hp_align_stage_if.sv
// Operand-in / aligned-out handshake bundle between the issue logic and the adder core.
interface hp_align_stage_if #(
    parameter int MANT_W = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a;
    logic [15:0]       in_b;
    logic              in_op;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant_big;
    logic [MANT_W-1:0] out_mant_small;
    logic [4:0]        out_exp_big;
    logic              out_sign_big;
    logic              out_sign_small;
    logic              out_sticky;
    logic [1:0]        out_cf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_mant_big, out_mant_small, out_exp_big,
               out_sign_big, out_sign_small, out_sticky, out_cf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_mant_big, out_mant_small, out_exp_big,
               out_sign_big, out_sign_small, out_sticky, out_cf
    );
endinterface

// File: rtl/hp_align_stage_shift.sv
// Combinational logical right shifter with sticky OR of every bit shifted out.
module hp_align_shift #(
    parameter int MANT_W  = 13,
    parameter int SHIFT_W = 4
) (
    input  logic [MANT_W-1:0]  mant_in,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [MANT_W-1:0]  mant_out,
    output logic               sticky
);

    // Lower half catches the discarded bits so sticky is a single reduction
    logic [2*MANT_W-1:0] wide;

    always_comb begin
        wide = {mant_in, {MANT_W{1'b0}}} >> shamt;
    end

    assign mant_out = wide[2*MANT_W-1:MANT_W];
    assign sticky   = |wide[MANT_W-1:0];

endmodule

// File: rtl/hp_align_stage.sv
// Two-stage binary16 operand alignment: classify and negate in S1, swap and shift in S2.
module hp_align_stage
    import fp_pkg::*;
#(
    parameter int MANT_W    = 13,
    parameter int SHIFT_MAX = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    hp_align_stage_if.slave io
);

    function automatic logic [3:0] sat_shift(input logic signed [5:0] d);
        logic [5:0] mag;
        mag = d[5] ? 6'(-d) : 6'(d);
        if (mag > 6'(SHIFT_MAX)) return 4'(SHIFT_MAX);
        return mag[3:0];
    endfunction

    function automatic cf_e classify(input logic [4:0] ea, input logic [4:0] eb);
        if (ea == '0 && eb == '0) return CF_SUBN;
        if (ea == 5'(HP_EXP_MAX) || eb == 5'(HP_EXP_MAX)) return CF_SPECIAL;
        return CF_NORM;
    endfunction

    logic s1_adv, s2_adv, accept;

    logic                vld_p1;
    logic                sa_p1, sb_p1;
    logic [4:0]          ea_p1, eb_p1;
    logic [MANT_W-1:0]   mant_a_p1, mant_b_p1;
    logic signed [5:0]   diff_p1;
    cf_e                 cf_p1;

    logic                vld_p2;
    logic [MANT_W-1:0]   mant_big_p2, mant_small_p2;
    logic [4:0]          exp_big_p2;
    logic                sign_big_p2, sign_small_p2, sticky_p2;
    cf_e                 cf_p2;

    assign s2_adv      = !vld_p2 || io.out_ready;
    assign s1_adv      = !vld_p1 || s2_adv;
    assign accept      = io.in_valid && s1_adv;
    assign io.in_ready = s1_adv;

    // ---- S1: field split, subtract negation, exponent difference, class ----
    logic signed [5:0] diff_c;
    assign diff_c = $signed({1'b0, io.in_a[14:10]}) - $signed({1'b0, io.in_b[14:10]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sa_p1     <= 1'b0;
            sb_p1     <= 1'b0;
            ea_p1     <= '0;
            eb_p1     <= '0;
            mant_a_p1 <= '0;
            mant_b_p1 <= '0;
            diff_p1   <= '0;
            cf_p1     <= CF_SPECIAL;
        end else begin
            if (s1_adv) vld_p1 <= io.in_valid;
            if (accept) begin
                sa_p1     <= io.in_a[15];
                sb_p1     <= io.in_b[15] ^ io.in_op;
                ea_p1     <= io.in_a[14:10];
                eb_p1     <= io.in_b[14:10];
                mant_a_p1 <= hp_mant(io.in_a);
                mant_b_p1 <= hp_mant(io.in_b);
                diff_p1   <= diff_c;
                cf_p1     <= classify(io.in_a[14:10], io.in_b[14:10]);
            end
        end
    end

    // ---- S1 -> S2: operand swap (ties keep A as big) and shifter ----
    logic              swap_c;
    logic [MANT_W-1:0] mant_small_c, mant_shifted_c;
    logic              sticky_c;
    logic [3:0]        shamt_c;

    assign swap_c       = diff_p1[5];
    assign mant_small_c = swap_c ? mant_a_p1 : mant_b_p1;
    assign shamt_c      = sat_shift(diff_p1);

    hp_align_shift #(
        .MANT_W (MANT_W),
        .SHIFT_W(4)
    ) u_shift (
        .mant_in (mant_small_c),
        .shamt   (shamt_c),
        .mant_out(mant_shifted_c),
        .sticky  (sticky_c)
    );

    // ---- S2: aligned result register, held while downstream stalls ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2        <= 1'b0;
            mant_big_p2   <= '0;
            mant_small_p2 <= '0;
            exp_big_p2    <= '0;
            sign_big_p2   <= 1'b0;
            sign_small_p2 <= 1'b0;
            sticky_p2     <= 1'b0;
            cf_p2         <= CF_SPECIAL;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mant_big_p2   <= swap_c ? mant_b_p1 : mant_a_p1;
                mant_small_p2 <= mant_shifted_c;
                exp_big_p2    <= swap_c ? eb_p1 : ea_p1;
                sign_big_p2   <= swap_c ? sb_p1 : sa_p1;
                sign_small_p2 <= swap_c ? sa_p1 : sb_p1;
                sticky_p2     <= sticky_c;
                cf_p2         <= cf_p1;
            end
        end
    end

    assign io.out_valid      = vld_p2;
    assign io.out_mant_big   = mant_big_p2;
    assign io.out_mant_small = mant_small_p2;
    assign io.out_exp_big    = exp_big_p2;
    assign io.out_sign_big   = sign_big_p2;
    assign io.out_sign_small = sign_small_p2;
    assign io.out_sticky     = sticky_p2;
    assign io.out_cf         = cf_p2;

endmodule
